// File: rtl/pfcu_stack_pkg.sv
// Shared definitions for the program-flow control unit: opcodes, status flag bits, FSM states.
// The return-address stack is only built when PFCU_RAS_EN is defined.
package pfcu_stack_pkg;

    localparam logic [3:0] PFCU_CLASS = 4'b1110;

    localparam logic [7:0] OP_JMP  = 8'h0E;
    localparam logic [7:0] OP_JIZ  = 8'h8E;
    localparam logic [7:0] OP_JNZ  = 8'h9E;
    localparam logic [7:0] OP_JIC  = 8'hAE;
    localparam logic [7:0] OP_CALL = 8'hCE;
    localparam logic [7:0] OP_RET  = 8'hDE;

    localparam int ZERO_BIT  = 0;
    localparam int CARRY_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESP,
        ST_HOLD
    } state_e;

    typedef struct packed {
        logic taken;
        logic fault;
    } res_t;

endpackage

// File: rtl/pfcu_stack_ras.sv
// Return-address stack: circular pointer over a register array with a separate occupancy count.
// Flush has priority over push/pop; push when full and pop when empty are ignored.
module pfcu_ras #(
    parameter int PC_W      = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [PC_W-1:0]            data_i,
    output logic [PC_W-1:0]            top_o,
    output logic [$clog2(RAS_DEPTH):0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [PC_W-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            do_push, do_pop;

    assign full_o  = (cnt_q == CW'(RAS_DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (do_push) begin
            ptr_d = ptr_q + PW'(1);
            cnt_d = cnt_q + CW'(1);
        end else if (do_pop) begin
            ptr_d = ptr_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry contents need no reset; the count guards every read.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[ptr_q] <= data_i;
    end

    assign top_o   = mem_q[ptr_q - PW'(1)];
    assign count_o = cnt_q;

endmodule

// File: rtl/pfcu_stack.sv
// Program-flow control unit: resolves jumps, conditional jumps and CALL/RET for the execute stage.
// CALL/RET and the return-address stack exist only when PFCU_RAS_EN is defined.
module pfcu_stack
    import pfcu_stack_pkg::*;
#(
    parameter int PC_W       = 32,
    parameter int INST_W     = 48,
    parameter int STATUS_W   = 8,
    parameter int RAS_DEPTH  = 8,
    parameter int INST_BYTES = 6
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       en_i,
    input  logic [INST_W-1:0]          inst_i,
    input  logic [PC_W-1:0]            cur_pc_i,
    input  logic [STATUS_W-1:0]        alu_status_i,
    input  logic                       ras_flush_i,
    output logic                       done_o,
    output logic                       mdfy_pc_o,
    output logic [PC_W-1:0]            new_pc_val_o,
    output logic                       fault_o,
    output logic [$clog2(RAS_DEPTH):0] ras_count_o
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    state_e          state_q, state_d;
    logic [7:0]      op;
    logic            accept;
    res_t            res_d, res_q;
    logic [PC_W-1:0] tgt_d, tgt_q;
    logic            done_q, mdfy_q, fault_q;
    logic [PC_W-1:0] new_pc_q;
    logic            resp;
    logic            unused_ok;

    assign op   = inst_i[7:0];
    assign resp = (state_q == ST_RESP);

`ifdef PFCU_RAS_EN
    logic            ras_push, ras_pop, ras_full, ras_empty;
    logic [PC_W-1:0] ras_top, ret_addr;
    logic [CW-1:0]   ras_cnt, ras_count_q;

    assign ret_addr = cur_pc_i + PC_W'(INST_BYTES);

    pfcu_ras #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .flush_i (ras_flush_i),
        .data_i  (ret_addr),
        .top_o   (ras_top),
        .count_o (ras_cnt),
        .full_o  (ras_full),
        .empty_o (ras_empty)
    );

    // Occupancy is reported one edge after the push/pop so it lines up with done.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ras_count_q <= '0;
        else         ras_count_q <= ras_cnt;
    end
    assign ras_count_o = ras_count_q;
`else
    assign ras_count_o = '0;
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        res_d   = '0;
        tgt_d   = inst_i[8 +: PC_W];
`ifdef PFCU_RAS_EN
        ras_push = 1'b0;
        ras_pop  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (en_i && op[3:0] == PFCU_CLASS) begin
                    accept  = 1'b1;
                    state_d = ST_RESP;
                    case (op)
                        OP_JMP: res_d.taken = 1'b1;
                        OP_JIZ: res_d.taken = alu_status_i[ZERO_BIT];
                        OP_JNZ: res_d.taken = !alu_status_i[ZERO_BIT];
                        OP_JIC: res_d.taken = alu_status_i[CARRY_BIT];
`ifdef PFCU_RAS_EN
                        OP_CALL: begin
                            if (ras_full) res_d.fault = 1'b1;
                            else begin
                                res_d.taken = 1'b1;
                                ras_push    = 1'b1;
                            end
                        end
                        // A coincident flush empties the stack first, so RET sees nothing to pop.
                        OP_RET: begin
                            if (ras_empty || ras_flush_i) res_d.fault = 1'b1;
                            else begin
                                res_d.taken = 1'b1;
                                tgt_d       = ras_top;
                                ras_pop     = 1'b1;
                            end
                        end
`endif
                        default: res_d.fault = 1'b1;
                    endcase
                end
            end
            ST_RESP: state_d = en_i ? ST_HOLD : ST_IDLE;
            ST_HOLD: if (!en_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            res_q    <= '0;
            tgt_q    <= '0;
            done_q   <= 1'b0;
            mdfy_q   <= 1'b0;
            fault_q  <= 1'b0;
            new_pc_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                res_q <= res_d;
                tgt_q <= tgt_d;
            end
            done_q  <= resp;
            mdfy_q  <= resp && res_q.taken;
            fault_q <= resp && res_q.fault;
            if (resp && res_q.taken) new_pc_q <= tgt_q;
        end
    end

    assign done_o       = done_q;
    assign mdfy_pc_o    = mdfy_q;
    assign fault_o      = fault_q;
    assign new_pc_val_o = new_pc_q;

    assign unused_ok = ^{inst_i, alu_status_i, cur_pc_i, ras_flush_i};

endmodule

// File: tb/tb_pfcu_stack.sv
// Randomised scoreboard bench for pfcu_stack; the reference model follows PFCU_RAS_EN like the RTL.
module tb_pfcu_stack;
    localparam int PC_W     = 32;
    localparam int INST_W   = 48;
    localparam int STATUS_W = 8;
    localparam int DEPTH    = 8;
    localparam int IB       = 6;
`ifdef PFCU_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              en = 1'b0;
    logic              flush = 1'b0;
    logic [INST_W-1:0] inst = '0;
    logic [PC_W-1:0]   cur_pc = '0;
    logic [7:0]        alu = '0;
    logic              done, mdfy, fault;
    logic [PC_W-1:0]   new_pc;
    logic [3:0]        ras_count;

    pfcu_stack #(
        .PC_W(PC_W), .INST_W(INST_W), .STATUS_W(STATUS_W),
        .RAS_DEPTH(DEPTH), .INST_BYTES(IB)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .inst_i(inst), .cur_pc_i(cur_pc),
        .alu_status_i(alu), .ras_flush_i(flush), .done_o(done), .mdfy_pc_o(mdfy),
        .new_pc_val_o(new_pc), .fault_o(fault), .ras_count_o(ras_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mdfy;
        logic        fault;
        logic [31:0] pc;
        int          cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] stk[$];
    logic [31:0] last_pc = '0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    function automatic logic [47:0] mk(input logic [7:0] op, input logic [31:0] tgt);
        return {8'h00, tgt, op};
    endfunction

    // Reference: outcome of one instruction from the opcode rules, stack as a plain queue.
    function automatic void model(input logic [47:0] ins, input logic [31:0] pc,
                                  input logic [7:0] st, input bit fl);
        logic [7:0]  op;
        logic [31:0] tgt;
        bit          taken, flt;
        bit          claimed;
        exp_t        e;
        op      = ins[7:0];
        tgt     = ins[39:8];
        taken   = 1'b0;
        flt     = 1'b0;
        claimed = (op[3:0] == 4'hE);
        if (claimed) begin
            case (op)
                8'h0E: taken = 1'b1;
                8'h8E: taken = st[0];
                8'h9E: taken = !st[0];
                8'hAE: taken = st[1];
                8'hCE: begin
                    if (!RAS_EN || stk.size() == DEPTH) flt = 1'b1;
                    else begin
                        taken = 1'b1;
                        stk.push_back(pc + 32'd6);
                    end
                end
                8'hDE: begin
                    if (!RAS_EN || stk.size() == 0 || fl) flt = 1'b1;
                    else begin
                        taken = 1'b1;
                        tgt   = stk.pop_back();
                    end
                end
                default: flt = 1'b1;
            endcase
        end
        if (fl && RAS_EN) stk.delete();
        if (claimed) begin
            if (taken) last_pc = tgt;
            e.mdfy  = taken;
            e.fault = flt;
            e.pc    = last_pc;
            e.cnt   = stk.size();
            exp_q.push_back(e);
        end
    endfunction

    // Present one instruction, hold en for `hold` extra cycles, scramble sampled inputs after accept.
    task automatic issue(input logic [47:0] ins, input logic [31:0] pc, input logic [7:0] st,
                         input bit fl, input int hold);
        @(negedge clk);
        en     = 1'b1;
        inst   = ins;
        cur_pc = pc;
        alu    = st;
        flush  = fl;
        model(ins, pc, st, fl);
        @(posedge clk);
        @(negedge clk);
        flush  = 1'b0;
        cur_pc = $urandom;
        alu    = 8'($urandom);
        repeat (hold) @(negedge clk);
        en = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 want no completion");
                end else begin
                    e = exp_q.pop_front();
                    chk("mdfy_pc", 64'(mdfy), 64'(e.mdfy));
                    chk("fault", 64'(fault), 64'(e.fault));
                    chk("new_pc_val", 64'(new_pc), 64'(e.pc));
                    chk("ras_count", 64'(ras_count), 64'(e.cnt));
                end
            end else if (mdfy || fault) begin
                chk("strobe_without_done", 64'({mdfy, fault}), 64'(0));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0]  op;
        logic [31:0] tgt;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_done", 64'(done), 0);
        chk("rst_mdfy", 64'(mdfy), 0);
        chk("rst_fault", 64'(fault), 0);
        chk("rst_new_pc", 64'(new_pc), 0);
        chk("rst_ras_count", 64'(ras_count), 0);
        rst_n = 1'b1;

        issue(mk(8'h0E, 32'h0000_1234), 32'h0, 8'h00, 1'b0, 2);
        issue(mk(8'h8E, 32'h0000_2000), 32'h0, 8'h01, 1'b0, 0);
        issue(mk(8'h8E, 32'h0000_2100), 32'h0, 8'h00, 1'b0, 0);
        issue(mk(8'h9E, 32'h0000_2200), 32'h0, 8'h01, 1'b0, 1);
        issue(mk(8'h9E, 32'h0000_2300), 32'h0, 8'h00, 1'b0, 0);
        issue(mk(8'hAE, 32'h0000_2400), 32'h0, 8'h02, 1'b0, 0);
        issue(mk(8'hAE, 32'h0000_2500), 32'h0, 8'h01, 1'b0, 0);

        issue(mk(8'hCE, 32'h0000_0400), 32'h0000_0100, 8'h00, 1'b0, 0);
        issue(mk(8'hDE, 32'h0000_0000), 32'h0000_0400, 8'h00, 1'b0, 0);

        for (int i = 0; i < DEPTH + 1; i++)
            issue(mk(8'hCE, 32'h0000_1000 + 32'(i)), 32'h0000_0800 + 32'(i * 16), 8'h00, 1'b0, 0);
        issue(mk(8'h0F, 32'h0), 32'h0, 8'h00, 1'b1, 0);
        issue(mk(8'hDE, 32'h0), 32'h0, 8'h00, 1'b0, 0);

        issue(mk(8'h3E, 32'h0000_9999), 32'h0, 8'h00, 1'b0, 0);
        issue(mk(8'h0F, 32'h0000_7777), 32'h0, 8'h00, 1'b0, 1);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0: op = 8'h0E;
                1: op = 8'h8E;
                2: op = 8'h9E;
                3: op = 8'hAE;
                4, 5: op = 8'hCE;
                6, 7: op = 8'hDE;
                8: op = {4'($urandom), 4'hE};
                default: begin
                    op = 8'($urandom);
                    if (op[3:0] == 4'hE) op[0] = 1'b1;
                end
            endcase
            tgt = $urandom;
            issue(mk(op, tgt), $urandom, 8'($urandom), ($urandom_range(0, 11) == 0),
                  $urandom_range(0, 2));
        end

        issue(mk(8'h0F, 32'h0), 32'h0, 8'h00, 1'b1, 0);
        for (int i = 0; i < 3; i++)
            issue(mk(8'hCE, 32'h0000_3000 + 32'(i)), 32'h0000_0200 + 32'(i * 8), 8'h00, 1'b0, 0);
        @(negedge clk);
        en   = 1'b1;
        inst = mk(8'h0E, 32'h0000_BEEF);
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_reset_done", 64'(done), 1);
        chk("pre_reset_ras_count", 64'(ras_count), 64'(stk.size()));
        rst_n = 1'b0;
        #1;
        chk("async_rst_done", 64'(done), 0);
        chk("async_rst_mdfy", 64'(mdfy), 0);
        chk("async_rst_new_pc", 64'(new_pc), 0);
        chk("async_rst_ras_count", 64'(ras_count), 0);
        exp_q.delete();
        stk.delete();
        last_pc = '0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(mk(8'h0E, 32'h0000_5555), 32'h0, 8'h00, 1'b0, 0);
        issue(mk(8'hDE, 32'h0), 32'h0, 8'h00, 1'b0, 0);

        repeat (4) @(negedge clk);
        chk("pending_completions", 64'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
